// File: rtl/alu_scheduler.sv
// Two-requester front end for a serial-operand ALU: round-robin arbitration,
// byte-serial operand load, result collection and a tagged valid/ready response.
module alu_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_opa,
    input  logic [7:0]  req0_opb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_opa,
    input  logic [7:0]  req1_opb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [1:0]  rsp_op,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        alu_reset,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    typedef enum logic [2:0] {
        IDLE, ARST, LD0, LD1, LD2, WAIT_END, CAP1, RESP
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              id_q;
    logic [1:0]        op_q;
    logic [15:0]       opa_q;
    logic [7:0]        opb_q;
    logic [7:0]        byte0_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              arst_q;
    logic              begin_q;
    logic [1:0]        alu_op_q;
    logic [7:0]        inbus_q;
    logic [15:0]       data_q;
    logic              rvalid_q;
    logic              timeout_q;

    logic grant;
    logic accept;
    logic is_div;

    // On a tie the requester that did not win last time gets the grant.
    assign grant      = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    assign req0_ready = (state_q == IDLE) && !reset && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && !reset && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign is_div     = (op_q == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            byte0_q      <= '0;
            cnt_q        <= '0;
            arst_q       <= 1'b0;
            begin_q      <= 1'b0;
            alu_op_q     <= '0;
            inbus_q      <= '0;
            data_q       <= '0;
            rvalid_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q         <= grant;
                        last_grant_q <= grant;
                        op_q         <= grant ? req1_op  : req0_op;
                        opa_q        <= grant ? req1_opa : req0_opa;
                        opb_q        <= grant ? req1_opb : req0_opb;
                        arst_q       <= 1'b1;
                        state_q      <= ARST;
                    end
                end
                ARST: begin
                    arst_q   <= 1'b0;
                    begin_q  <= 1'b1;
                    alu_op_q <= op_q;
                    inbus_q  <= is_div ? opa_q[15:8] : opa_q[7:0];
                    state_q  <= LD0;
                end
                LD0: begin
                    begin_q <= 1'b0;
                    inbus_q <= is_div ? opa_q[7:0] : opb_q;
                    state_q <= LD1;
                end
                LD1: begin
                    cnt_q <= '0;
                    if (is_div) begin
                        inbus_q <= opb_q;
                        state_q <= LD2;
                    end else begin
                        inbus_q <= '0;
                        state_q <= WAIT_END;
                    end
                end
                LD2: begin
                    cnt_q   <= '0;
                    inbus_q <= '0;
                    state_q <= WAIT_END;
                end
                WAIT_END: begin
                    cnt_q <= cnt_q + 1'b1;
                    // END has priority over the watchdog on its final cycle.
                    if (alu_end) begin
                        byte0_q <= alu_outbus;
                        if (op_q[1]) begin
                            state_q <= CAP1;
                        end else begin
                            data_q   <= {8'h00, alu_outbus};
                            rvalid_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        data_q    <= '0;
                        rvalid_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                CAP1: begin
                    data_q   <= {byte0_q, alu_outbus};
                    rvalid_q <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rvalid_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        alu_op_q  <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rvalid_q;
    assign rsp_id      = id_q;
    assign rsp_op      = op_q;
    assign rsp_data    = data_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != IDLE);
    assign alu_reset   = reset || arst_q;
    assign alu_begin   = begin_q;
    assign alu_op_code = alu_op_q;
    assign alu_inbus   = inbus_q;

endmodule
